// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard unit for a five-stage in-order pipeline (F/D/E/M/W).
//
// It provides:
//   * operand forwarding for the Execute stage (M result has priority over W)
//   * load-use stall detection (load in E feeding an instruction in D)
//   * a memory-wait stall when the data memory does not acknowledge an M access
//   * pipeline enables and synchronous clears for the PC and the D/E/M/W regs
//   * a saturating counter of stall cycles
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   Rs1D, Rs2D   in   [4:0] source registers of the Decode instruction
//   Rs1E, Rs2E   in   [4:0] source registers of the Execute instruction
//   RdE          in   [4:0] destination of the Execute instruction
//   RdM, RdW     in   [4:0] destinations in Memory and Writeback
//   RegWriteM/W  in   register-write valid in M and W
//   LoadE        in   Execute instruction is a load
//   PCSrcE       in   branch/jump taken, resolved in Execute
//   MemReqM      in   data-memory access in M
//   MemReadyM    in   data-memory completion acknowledge
//   StallCntClr  in   synchronous clear of StallCnt
//   ForwardAE/BE out  [1:0] ALU operand select: 00 regfile, 01 W result, 10 M result
//   EnF..EnW     out  enables for PC and D/E/M/W pipeline registers
//   ClrD/E/W     out  synchronous clears (act only when the matching enable is 1)
//   StallCnt     out  [CNTW-1:0] saturating count of stall cycles
//   state_dbg    out  current memory-wait FSM state (0 RUN, 1 MEMWAIT)
//
// Handshake: the M-stage access is a request/acknowledge pair. MemReqM is held
// by the pipeline while the access is outstanding; the access completes in the
// cycle where MemReqM (or the recorded wait) coincides with MemReadyM=1. A
// completion releases the stall in that same cycle, so no extra bubble is added.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic [4:0]      RdM,
  input  logic [4:0]      RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            LoadE,
  input  logic            PCSrcE,
  input  logic            MemReqM,
  input  logic            MemReadyM,
  input  logic            StallCntClr,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            EnF,
  output logic            EnD,
  output logic            EnE,
  output logic            EnM,
  output logic            EnW,
  output logic            ClrD,
  output logic            ClrE,
  output logic            ClrW,
  output logic [CNTW-1:0] StallCnt,
  output logic            state_dbg
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t state;
  state_t state_nxt;
  logic   mem_stall;
  logic   lw_stall;
  logic   any_stall;

  // ---------------------------------------------------------------------------
  // Forwarding: M beats W because M holds the younger write to the register.
  // x0 is hard-wired to zero, so it is never forwarded.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m,
                                         input logic [4:0] rd_m,
                                         input logic       rw_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the loaded value is not available until after M, so the
  // dependent instruction in D must wait one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memStall. The stall is combinational so the first cycle of
  // an unacknowledged access already freezes the pipe, and the acknowledge
  // cycle in MEMWAIT already releases it.
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall = 1'b1;
          state_nxt = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_nxt = RUN;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Pipeline control. A memory stall freezes F..M and pushes a bubble into W;
  // it overrides load-use and branch flush. A taken branch that sat in E
  // during the freeze is still there afterwards, so its flush happens in the
  // first un-stalled cycle without any extra bookkeeping.
  // ---------------------------------------------------------------------------
  always_comb begin
    EnF  = 1'b1;
    EnD  = 1'b1;
    EnE  = 1'b1;
    EnM  = 1'b1;
    EnW  = 1'b1;
    ClrD = 1'b0;
    ClrE = 1'b0;
    ClrW = 1'b0;
    if (mem_stall) begin
      EnF  = 1'b0;
      EnD  = 1'b0;
      EnE  = 1'b0;
      EnM  = 1'b0;
      ClrW = 1'b1;
    end else begin
      EnF  = !lw_stall;
      EnD  = !lw_stall;
      ClrD = PCSrcE;
      ClrE = lw_stall || PCSrcE;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle counter: saturates at all-ones; clear wins over increment.
  // ---------------------------------------------------------------------------
  assign any_stall = mem_stall || lw_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
    end else if (StallCntClr) begin
      StallCnt <= '0;
    end else if (any_stall && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios followed by randomized cycles, all checked against a
// reference model of the hazard rules. The DUT is built with a 4-bit counter
// so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, StallCntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW;
  logic [CNTW-1:0] StallCnt;
  logic state_dbg;

  hazard_ctrl #(.CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallCntClr(StallCntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
    .ClrD(ClrD), .ClrE(ClrE), .ClrW(ClrW),
    .StallCnt(StallCnt), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // scoreboard and reference model
  // ---------------------------------------------------------------------------
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: "waiting" means an access was left unacknowledged last
  // cycle; cnt is a plain integer clamped to the counter range.
  bit model_wait = 1'b0;
  int model_cnt  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_mem_stall();
    // Stalled whenever the memory has not acknowledged an access that is
    // either newly requested or already pending.
    return (model_wait || MemReqM) && !MemReadyM;
  endfunction

  function automatic bit ref_lw_stall();
    return LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // Packed as {ForwardAE, ForwardBE, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW}
  function automatic logic [11:0] ref_outs();
    bit ms, lw;
    logic [4:0] en;
    logic [2:0] clr;
    ms = ref_mem_stall();
    lw = ref_lw_stall();
    if (ms) begin
      en  = 5'b00001;
      clr = 3'b001;
    end else begin
      en  = {~lw, ~lw, 3'b111};
      clr = {PCSrcE, lw | PCSrcE, 1'b0};
    end
    return {ref_fwd(Rs1E), ref_fwd(Rs2E), en, clr};
  endfunction

  function automatic logic [11:0] dut_outs();
    return {ForwardAE, ForwardBE, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrW};
  endfunction

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0; StallCntClr = 0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then advance the
  // model across the edge and check the registered state just after it.
  task automatic step(input string tag);
    bit stall;
    exp_q.push_back(ref_outs());
    @(negedge clk);
    check({tag, "_outs"}, 16'(dut_outs()), 16'(exp_q.pop_front()));
    stall = ref_mem_stall() || ref_lw_stall();
    @(posedge clk);
    if (StallCntClr) model_cnt = 0;
    else if (stall && model_cnt < CMAX) model_cnt++;
    model_wait = ref_mem_stall();
    #1;
    check({tag, "_cnt"}, 16'(StallCnt), 16'(model_cnt));
    check({tag, "_state"}, 16'(state_dbg), 16'(model_wait));
  endtask

  task automatic clear_cnt();
    idle();
    StallCntClr = 1;
    step("clr");
    StallCntClr = 0;
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    reset = 1'b1;
    #2;
    check("reset_outs", 16'(dut_outs()), 16'(ref_outs()));
    check("reset_cnt", 16'(StallCnt), 16'd0);
    check("reset_state", 16'(state_dbg), 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Forwarding priority: M over W, then W alone, then x0 never forwarded.
    idle();
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
    step("fwd_m");
    check("fwd_m_a", 16'(ForwardAE), 16'b10);
    RegWriteM = 0;
    step("fwd_w");
    check("fwd_w_a", 16'(ForwardAE), 16'b01);
    Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
    step("fwd_0");
    check("fwd_0_a", 16'(ForwardAE), 16'b00);

    // Load-use stall, then the same with RdE=0 (no stall).
    clear_cnt();
    idle();
    LoadE = 1; RdE = 7; Rs2D = 7;
    step("lw");
    check("lw_cnt1", 16'(StallCnt), 16'd1);
    RdE = 0;
    step("lw_x0");
    check("lw_x0_cnt", 16'(StallCnt), 16'd1);

    // Memory wait of 3 cycles with a taken branch held in E throughout.
    clear_cnt();
    idle();
    PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    repeat (3) step("mwait");
    MemReadyM = 1;
    step("mrel");
    check("mwait_cnt3", 16'(StallCnt), 16'd3);
    check("mwait_run", 16'(state_dbg), 16'd0);

    // Zero-wait access causes nothing.
    idle();
    MemReqM = 1; MemReadyM = 1;
    step("zero_wait");

    // Saturation after 20 load-use stalls, then clear beating an increment.
    clear_cnt();
    idle();
    LoadE = 1; RdE = 3; Rs1D = 3;
    repeat (20) step("sat");
    check("sat_cnt", 16'(StallCnt), 16'(CMAX));
    StallCntClr = 1;
    step("clr_vs_inc");
    check("clr_vs_inc_cnt", 16'(StallCnt), 16'd0);

    // Reset in the middle of a memory wait.
    idle();
    MemReqM = 1; MemReadyM = 0;
    step("pre_rst");
    step("pre_rst");
    MemReqM = 0;
    #2;
    check("in_wait_clrw", 16'(ClrW), 16'd1);
    reset = 1'b1;
    model_wait = 1'b0;
    model_cnt  = 0;
    #1;
    check("rst_mid_clrw", 16'(ClrW), 16'd0);
    check("rst_mid_enf", 16'(EnF), 16'd1);
    check("rst_mid_cnt", 16'(StallCnt), 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step("post_rst");
    step("post_rst");
    check("post_rst_run", 16'(state_dbg), 16'd0);

    // Randomized cycles over a small register range so hazards are common.
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      LoadE = 1'($urandom); PCSrcE = 1'($urandom_range(0, 3) == 0);
      MemReqM = 1'($urandom); MemReadyM = 1'($urandom);
      StallCntClr = 1'($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
